// File: rtl/key_event_pkg.sv
// Shared types and count constants for the key event decoder.
`timescale 1ns/1ps
package key_event_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        WAIT_2ND,
        PRESSED_2,
        LONG_HELD
    } key_state_e;

    // Counts for a 50 MHz clock
    localparam int DEF_LONG_CNT   = 50_000_000;
    localparam int DEF_DCLICK_CNT = 15_000_000;
    localparam int DEF_REPEAT_CNT = 5_000_000;
    localparam int DEF_CNT_W      = 26;

    // Shortened counts so simulations finish quickly
    localparam int SIM_LONG_CNT   = 100;
    localparam int SIM_DCLICK_CNT = 40;
    localparam int SIM_REPEAT_CNT = 20;

endpackage

// File: rtl/key_edge_detect.sv
// Registers the debounced key level and decodes press/release edges (key is active-low).
`timescale 1ns/1ps
module key_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_db,
    output logic o_press,
    output logic o_release
);

    logic r_key_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_key_q <= 1'b1;
        end else begin
            r_key_q <= i_key_db;
        end
    end

    assign o_press   = r_key_q & ~i_key_db;
    assign o_release = ~r_key_q & i_key_db;

endmodule

// File: rtl/key_event_decoder.sv
// Turns the debounced key level into press/release/single/double/long event pulses.
// Optional auto-repeat while held is built when KEY_REPEAT_EN is defined.
`timescale 1ns/1ps
module key_event_decoder
    import key_event_pkg::*;
#(
    parameter int LONG_CNT   = DEF_LONG_CNT,
    parameter int DCLICK_CNT = DEF_DCLICK_CNT,
    parameter int REPEAT_CNT = DEF_REPEAT_CNT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic key_db,
    output logic press_p,
    output logic release_p,
    output logic single_p,
    output logic double_p,
    output logic long_p,
    output logic repeat_p,
    output logic key_down
);

    localparam longint unsigned MAX_A   = (LONG_CNT > DCLICK_CNT) ? LONG_CNT : DCLICK_CNT;
    localparam longint unsigned MAX_CNT = (MAX_A > REPEAT_CNT) ? MAX_A : REPEAT_CNT;

    if (LONG_CNT < 2 || DCLICK_CNT < 2) begin : g_cnt_min_check
        $error("key_event_decoder: LONG_CNT and DCLICK_CNT must be >= 2");
    end
    if (MAX_CNT > ((64'd1 << CNT_W) - 64'd1)) begin : g_cnt_w_check
        $error("key_event_decoder: CNT_W too narrow for the configured counts");
    end

    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_CNT - 1);

    logic             w_press;
    logic             w_release;
    key_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;

    key_edge_detect u_edge (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_key_db  (key_db),
        .o_press   (w_press),
        .o_release (w_release)
    );

    // Key edges take priority over any timer terminal reached in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            press_p   <= 1'b0;
            release_p <= 1'b0;
            single_p  <= 1'b0;
            double_p  <= 1'b0;
            long_p    <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            press_p   <= w_press;
            release_p <= w_release;
            key_down  <= ~key_db;
            single_p  <= 1'b0;
            double_p  <= 1'b0;
            long_p    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_press) r_state <= PRESSED;
                end
                PRESSED: begin
                    if (w_release) begin
                        r_state <= WAIT_2ND;
                        r_cnt   <= '0;
                    end else if (r_cnt == LONG_TC) begin
                        long_p  <= 1'b1;
                        r_state <= LONG_HELD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_2ND: begin
                    if (w_press) begin
                        r_state <= PRESSED_2;
                        r_cnt   <= '0;
                    end else if (r_cnt == DCLICK_TC) begin
                        single_p <= 1'b1;
                        r_state  <= IDLE;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PRESSED_2: begin
                    if (w_release) begin
                        double_p <= 1'b1;
                        r_state  <= IDLE;
                        r_cnt    <= '0;
                    end else if (r_cnt == LONG_TC) begin
                        long_p  <= 1'b1;
                        r_state <= LONG_HELD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                LONG_HELD: begin
                    r_cnt <= '0;
                    if (w_release) r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CNT - 1);

    logic [CNT_W-1:0] r_rpt_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rpt_cnt <= '0;
            repeat_p  <= 1'b0;
        end else begin
            repeat_p <= 1'b0;
            if (r_state == LONG_HELD && !w_release) begin
                if (r_rpt_cnt == REPEAT_TC) begin
                    repeat_p  <= 1'b1;
                    r_rpt_cnt <= '0;
                end else begin
                    r_rpt_cnt <= r_rpt_cnt + 1'b1;
                end
            end else begin
                r_rpt_cnt <= '0;
            end
        end
    end
`else
    assign repeat_p = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder using the shortened simulation counts.
`timescale 1ns/1ps
module tb_key_event_decoder;
    import key_event_pkg::*;

`ifdef KEY_REPEAT_EN
    localparam int RPT_EN = 1;
`else
    localparam int RPT_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_db = 1'b1;
    logic press_p, release_p, single_p, double_p, long_p, repeat_p, key_down;

    key_event_decoder #(
        .LONG_CNT   (SIM_LONG_CNT),
        .DCLICK_CNT (SIM_DCLICK_CNT),
        .REPEAT_CNT (SIM_REPEAT_CNT),
        .CNT_W      (26)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_db    (key_db),
        .press_p   (press_p),
        .release_p (release_p),
        .single_p  (single_p),
        .double_p  (double_p),
        .long_p    (long_p),
        .repeat_p  (repeat_p),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_pass = 0, n_total = 0;
    int n_press, n_release, n_single, n_double, n_long, n_repeat;
    int t_press, t_release, t_single, t_double, t_long, t_rpt_first, t_rpt_last;
    int n_viol = 0;
    logic [5:0] prev_p = '0;

    // Event log sampled mid-cycle, plus one-hot and one-cycle-width rules.
    always @(negedge clk) begin
        logic [5:0] cur;
        cur = {press_p, release_p, single_p, double_p, long_p, repeat_p};
        if (press_p)   begin n_press++;   t_press   = cyc; end
        if (release_p) begin n_release++; t_release = cyc; end
        if (single_p)  begin n_single++;  t_single  = cyc; end
        if (double_p)  begin n_double++;  t_double  = cyc; end
        if (long_p)    begin n_long++;    t_long    = cyc; end
        if (repeat_p) begin
            if (n_repeat == 0) t_rpt_first = cyc;
            n_repeat++;
            t_rpt_last = cyc;
        end
        if ((int'(single_p) + int'(double_p) + int'(long_p)) > 1) n_viol++;
        if (|(cur & prev_p)) n_viol++;
        prev_p = cur;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic clear_counts();
        n_press = 0; n_release = 0; n_single = 0; n_double = 0; n_long = 0; n_repeat = 0;
        t_press = -1; t_release = -1; t_single = -1; t_double = -1; t_long = -1;
        t_rpt_first = -1; t_rpt_last = -1;
    endtask

    task automatic hold(input logic lvl, input int n);
        key_db = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int outs();
        return int'({press_p, release_p, single_p, double_p, long_p, repeat_p, key_down});
    endfunction

    typedef struct {
        int p1;       // first press length in cycles
        int gap;      // release gap before second press
        int p2;       // second press length, 0 = no second press
        int e_single;
        int e_double;
        int e_long;
        int e_repeat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        clear_counts();
        vecs[0] = '{10,  0,   0, 1, 0, 0, 0};
        vecs[1] = '{10, 15,  10, 0, 1, 0, 0};
        vecs[2] = '{310, 0,   0, 0, 0, 1, 10 * RPT_EN};
        vecs[3] = '{99,  0,   0, 1, 0, 0, 0};
        vecs[4] = '{100, 0,   0, 1, 0, 0, 0};
        vecs[5] = '{101, 0,   0, 0, 0, 1, 0};
        vecs[6] = '{10, 40,  10, 0, 1, 0, 0};
        vecs[7] = '{10, 39,  10, 0, 1, 0, 0};
        vecs[8] = '{10, 41,  10, 2, 0, 0, 0};
        vecs[9] = '{10, 15, 150, 0, 0, 1, 2 * RPT_EN};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", outs(), 0);

        // Key held low through reset
        key_db = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("held-in-reset outputs", outs(), 0);
        clear_counts();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("press_p after reset", int'(press_p), 1);
        chk("key_down after reset", int'(key_down), 1);
        hold(0, 9);
        hold(1, 60);
        chk("held-reset single", n_single, 1);

        for (int i = 0; i < 10; i++) begin
            clear_counts();
            hold(0, vecs[i].p1);
            if (vecs[i].p2 > 0) begin
                hold(1, vecs[i].gap);
                hold(0, vecs[i].p2);
            end
            hold(1, 60);
            chk($sformatf("row%0d press count", i), n_press, (vecs[i].p2 > 0) ? 2 : 1);
            chk($sformatf("row%0d release count", i), n_release, (vecs[i].p2 > 0) ? 2 : 1);
            chk($sformatf("row%0d single count", i), n_single, vecs[i].e_single);
            chk($sformatf("row%0d double count", i), n_double, vecs[i].e_double);
            chk($sformatf("row%0d long count", i), n_long, vecs[i].e_long);
            chk($sformatf("row%0d repeat count", i), n_repeat, vecs[i].e_repeat);
            if (vecs[i].e_single > 0)
                chk($sformatf("row%0d single delay", i), t_single - t_release, SIM_DCLICK_CNT);
            if (vecs[i].e_double > 0)
                chk($sformatf("row%0d double vs release", i), t_double - t_release, 0);
            if (vecs[i].e_long > 0)
                chk($sformatf("row%0d long delay", i), t_long - t_press, SIM_LONG_CNT);
            if (n_repeat > 0) begin
                chk($sformatf("row%0d first repeat delay", i), t_rpt_first - t_long, SIM_REPEAT_CNT);
                chk($sformatf("row%0d repeat spacing", i), t_rpt_last - t_rpt_first,
                    SIM_REPEAT_CNT * (n_repeat - 1));
            end
        end

        // Reset while waiting for a second press drops the pending single click
        clear_counts();
        hold(0, 10);
        hold(1, 20);
        rst = 1'b1;
        #1;
        chk("mid-reset outputs", outs(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1, 60);
        chk("mid-reset no single", n_single, 0);
        chk("mid-reset no double", n_double, 0);

        clear_counts();
        hold(0, 10);
        hold(1, 60);
        chk("post-reset single count", n_single, 1);
        chk("post-reset single delay", t_single - t_release, SIM_DCLICK_CNT);
        chk("post-reset press to release", t_release - t_press, 10);

        chk("pulse rules", n_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
